// File: rtl/rotate_frame_ctrl.sv
// rotate_frame_ctrl: sequences the rotation core through write and rotated read phases and
// turns its fixed-latency read port into a back-pressurable output stream with line/frame marks.
module rotate_frame_ctrl #(
   parameter int IMG_W = 1024,
   parameter int IMG_H = 1024,
   parameter int CNT_W = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       frame_done,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_sol,
   output logic       out_eof,
   output logic       core_mode,
   output logic       core_ce,
   output logic       core_clr,
   output logic [7:0] core_wdata,
   input  logic [7:0] core_rdata
);
   typedef enum logic [2:0] {IDLE, CLR_W, LOAD, CLR_R, ROTATE, DRAIN, DONE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_W * IMG_H - 1);
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_H - 1);
   state_t state, state_nx;
   logic [CNT_W-1:0] pix_cnt, out_idx, col;
   logic [1:0] fifo_cnt;
   logic [7:0] d0, d1;
   logic rd_pend, pop;
   assign pop = out_valid & out_ready;
   assign out_valid = fifo_cnt != 2'd0;
   assign out_data = d0;
   assign out_sol = out_valid & (col == '0);
   assign out_eof = out_valid & (out_idx == LAST);
   assign core_wdata = in_data;
   always_comb begin
      state_nx = state;
      busy = 1'b1;
      frame_done = 1'b0;
      in_ready = 1'b0;
      core_ce = 1'b0;
      core_clr = 1'b0;
      core_mode = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            state_nx = start ? CLR_W : IDLE;
         end
         CLR_W: begin
            core_clr = 1'b1;
            state_nx = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            core_ce = in_valid;
            state_nx = (in_valid && pix_cnt == LAST) ? CLR_R : LOAD;
         end
         CLR_R: begin
            core_clr = 1'b1;
            core_mode = 1'b1;
            state_nx = ROTATE;
         end
         ROTATE: begin
            core_mode = 1'b1;
            // occupancy is taken after this cycle's pop so a full-rate stream never bubbles
            core_ce = ({1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, pop}) < 3'd2;
            state_nx = (core_ce && pix_cnt == LAST) ? DRAIN : ROTATE;
         end
         DRAIN: begin
            core_mode = 1'b1;
            state_nx = (pop && out_eof) ? DONE : DRAIN;
         end
         DONE: begin
            busy = 1'b0;
            frame_done = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            busy = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pix_cnt <= '0;
         out_idx <= '0;
         col <= '0;
         fifo_cnt <= '0;
         d0 <= '0;
         d1 <= '0;
         rd_pend <= 1'b0;
      end else begin
         state <= state_nx;
         rd_pend <= core_ce & core_mode;
         fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
         if (core_clr) pix_cnt <= '0;
         else if (core_ce) pix_cnt <= pix_cnt + CNT_W'(1);
         if (core_clr) begin
            out_idx <= '0;
            col <= '0;
         end else if (pop) begin
            out_idx <= out_idx + CNT_W'(1);
            col <= (col == COL_LAST) ? '0 : col + CNT_W'(1);
         end
         if (pop) d0 <= (fifo_cnt == 2'd2) ? d1 : core_rdata;
         else if (rd_pend && fifo_cnt == 2'd0) d0 <= core_rdata;
         if (rd_pend && fifo_cnt == (pop ? 2'd2 : 2'd1)) d1 <= core_rdata;
      end
   end
endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// tb_rotate_frame_ctrl: drives a 4x4 and a 2x3 instance, each with a behavioural rotation core,
// through a table of frame scenarios; a scoreboard holds the expected rotated stream.
module tb_rotate_frame_ctrl;
   typedef struct {
      logic [7:0] data;
      bit sol;
      bit eof;
      int k;
   } sb_t;
   typedef struct {
      int d;
      int gap;
      int stall_at;
      int stall_len;
      int rnd;
      bit poke;
      bit tim;
      bit thr;
      bit abort;
      int base;
      int exp_n;
      int exp_fd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] start = '0, in_valid = '0, out_ready = '0;
   logic [1:0][7:0] in_data = '0;
   wire [1:0] busy, frame_done, in_ready, out_valid, out_sol, out_eof, core_mode, core_ce, core_clr;
   wire [1:0][7:0] out_data, core_wdata;
   int tests = 0, fails = 0;
   sb_t q0[$], q1[$];

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void sb_push(int d, sb_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic sb_t sb_pop(int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   function automatic int sb_size(int d);
      return d == 0 ? q0.size() : q1.size();
   endfunction

   function automatic void sb_clear(int d);
      if (d == 0) q0.delete();
      else q1.delete();
   endfunction

   function automatic int wof(int d);
      return d == 0 ? 4 : 2;
   endfunction

   function automatic int hof(int d);
      return d == 0 ? 4 : 3;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : tbg
      localparam int W = (g == 0) ? 4 : 2;
      localparam int H = (g == 0) ? 4 : 3;
      logic [7:0] mem [16];
      logic [7:0] rdata = '0;
      int addr = 0;
      int ce_w = 0, ce_r = 0, fd = 0, iss = 0, acc = 0, mx = 0, cyc = 0, c_first = 0, span = 0;
      logic [7:0] p_data = '0;
      logic p_sol = 1'b0, p_eof = 1'b0, p_stall = 1'b0;
      sb_t e;

      rotate_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(5)) dut (
         .clk(clk), .rst(rst_n), .start(start[g]), .busy(busy[g]), .frame_done(frame_done[g]),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
         .out_sol(out_sol[g]), .out_eof(out_eof[g]), .core_mode(core_mode[g]),
         .core_ce(core_ce[g]), .core_clr(core_clr[g]), .core_wdata(core_wdata[g]),
         .core_rdata(rdata)
      );

      // rotation core: raster write order, CCW read order (line r = source column W-1-r)
      always @(posedge clk) begin
         if (core_clr[g]) addr <= 0;
         else if (core_ce[g]) begin
            if (!core_mode[g]) mem[4'(addr)] <= core_wdata[g];
            else rdata <= mem[4'((addr % H) * W + W - 1 - addr / H)];
            addr <= addr + 1;
         end
      end

      always @(negedge clk) begin
         cyc++;
         if (!rst_n) p_stall = 1'b0;
         else begin
            if (p_stall) begin
               check("stall_valid", out_valid[g], 1);
               check("stall_data", out_data[g], p_data);
               check("stall_sol", out_sol[g], p_sol);
               check("stall_eof", out_eof[g], p_eof);
            end
            if (core_clr[g] && core_mode[g]) begin
               iss = 0;
               acc = 0;
               mx = 0;
            end
            if (core_ce[g] && core_mode[g]) begin
               ce_r++;
               iss++;
            end
            if (core_ce[g] && !core_mode[g]) ce_w++;
            if (frame_done[g]) fd++;
            if (out_valid[g] && out_ready[g]) begin
               acc++;
               check("sb_nonempty", int'(sb_size(g) > 0), 1);
               if (sb_size(g) > 0) begin
                  e = sb_pop(g);
                  check("out_data", out_data[g], e.data);
                  check("out_sol", out_sol[g], e.sol);
                  check("out_eof", out_eof[g], e.eof);
                  if (e.k == 0) c_first = cyc;
                  if (e.eof) span = cyc - c_first;
               end
            end
            if (iss - acc > mx) mx = iss - acc;
            p_stall = out_valid[g] && !out_ready[g];
            p_data = out_data[g];
            p_sol = out_sol[g];
            p_eof = out_eof[g];
         end
      end
   end

   function automatic int mon(int d, int sel);
      if (d == 0)
         return sel == 0 ? tbg[0].ce_w : sel == 1 ? tbg[0].ce_r : sel == 2 ? tbg[0].fd :
                sel == 3 ? tbg[0].mx : tbg[0].span;
      return sel == 0 ? tbg[1].ce_w : sel == 1 ? tbg[1].ce_r : sel == 2 ? tbg[1].fd :
             sel == 3 ? tbg[1].mx : tbg[1].span;
   endfunction

   task automatic chk_reset(input int d, input string tag);
      check({tag, "_busy"}, busy[d], 0);
      check({tag, "_frame_done"}, frame_done[d], 0);
      check({tag, "_in_ready"}, in_ready[d], 0);
      check({tag, "_out_valid"}, out_valid[d], 0);
      check({tag, "_out_sol"}, out_sol[d], 0);
      check({tag, "_out_eof"}, out_eof[d], 0);
      check({tag, "_out_data"}, out_data[d], 0);
      check({tag, "_core_mode"}, core_mode[d], 0);
      check({tag, "_core_ce"}, core_ce[d], 0);
      check({tag, "_core_clr"}, core_clr[d], 0);
   endtask

   task automatic run_frame(input vec_t v);
      int d, w, h, n, k, cyc, ce_w0, ce_r0, fd0;
      logic [7:0] pix [16];
      bit acc, poked, done;
      sb_t e;
      d = v.d;
      w = wof(d);
      h = hof(d);
      n = w * h;
      for (int i = 0; i < n; i++) pix[i] = 8'(v.base + i);
      for (int j = 0; j < n; j++) begin
         e.data = pix[(j % h) * w + w - 1 - j / h];
         e.sol = (j % h) == 0;
         e.eof = j == n - 1;
         e.k = j;
         sb_push(d, e);
      end
      ce_w0 = mon(d, 0);
      ce_r0 = mon(d, 1);
      fd0 = mon(d, 2);
      out_ready[d] = !v.abort;
      start[d] = 1'b1;
      @(negedge clk);
      if (v.tim) check("t0_busy", busy[d], 0);
      @(posedge clk);
      #1 start[d] = 1'b0;
      @(negedge clk);
      if (v.tim) begin
         check("t1_busy", busy[d], 1);
         check("t1_core_clr", core_clr[d], 1);
         check("t1_in_ready", in_ready[d], 0);
      end
      @(posedge clk);
      #1;
      k = 0;
      cyc = 0;
      poked = 0;
      while (k < n && cyc < 500) begin
         in_valid[d] = v.gap == 0 || $urandom_range(99) >= v.gap;
         in_data[d] = pix[k];
         start[d] = v.poke && !poked && k == n / 2;
         poked = poked | start[d];
         @(negedge clk);
         if (v.tim && cyc == 0) check("t2_in_ready", in_ready[d], 1);
         acc = in_valid[d] && in_ready[d];
         @(posedge clk);
         #1;
         if (acc) k++;
         cyc++;
      end
      in_valid[d] = 1'b0;
      start[d] = 1'b0;
      if (k < n) begin
         check("load_timeout", k, n);
         sb_clear(d);
         return;
      end
      if (v.tim) begin
         @(negedge clk);
         check("tl1_clr_r", {core_clr[d], core_mode[d]}, 3);
         @(negedge clk);
         check("tl2_core_ce", core_ce[d], 1);
         @(negedge clk);
         check("tl3_out_valid", out_valid[d], 0);
         @(negedge clk);
         check("tl4_out_valid", out_valid[d], 1);
         @(posedge clk);
         #1;
      end
      cyc = 0;
      done = 0;
      while (!done && cyc < 500) begin
         out_ready[d] = !v.abort && !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len) &&
                        (v.rnd == 0 || $urandom_range(99) >= v.rnd);
         start[d] = v.poke && out_valid[d] && out_eof[d];
         @(negedge clk);
         if (v.abort && out_valid[d]) begin
            #2 rst_n = 1'b0;
            #1 chk_reset(d, "mid_rst");
            sb_clear(d);
            @(posedge clk);
            @(negedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         done = frame_done[d];
         if (done) check("done_busy_low", busy[d], 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      start[d] = 1'b0;
      if (!done) begin
         check("frame_timeout", int'(done), 1);
         sb_clear(d);
         return;
      end
      repeat (3) @(posedge clk);
      #1;
      check("frame_done_count", mon(d, 2) - fd0, v.exp_fd);
      check("core_ce_write", mon(d, 0) - ce_w0, v.exp_n);
      check("core_ce_read", mon(d, 1) - ce_r0, v.exp_n);
      check("outputs_all_seen", sb_size(d), 0);
      check("idle_after_frame", busy[d], 0);
      check("max_buffered_le2", int'(mon(d, 3) <= 2), 1);
      if (v.thr) check("throughput_span", mon(d, 4), v.exp_n - 1);
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 16, 1};
      tbl[1] = '{0, 50, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16, 1};
      tbl[2] = '{0, 0, 4, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 40, 16, 1};
      tbl[3] = '{0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16, 1};
      tbl[4] = '{0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16, 1};
      tbl[5] = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 100, 16, 0};
      tbl[6] = '{0, 30, 0, 0, 30, 1'b0, 1'b0, 1'b0, 1'b0, 7, 16, 1};
      tbl[7] = '{1, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 6, 1};
      tbl[8] = '{1, 50, 2, 5, 40, 1'b1, 1'b0, 1'b0, 1'b0, 200, 6, 1};
      #2;
      chk_reset(0, "por0");
      chk_reset(1, "por1");
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) run_frame(tbl[i]);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/rotate_frame_ctrl.md
# rotate_frame_ctrl

Frame-level controller that sequences the 90° CCW image-rotation core through a write-frame phase and a rotated read-out phase. It accepts an upstream pixel stream with valid/ready flow control and converts the rotation core's free-running, fixed-latency read port into a back-pressurable output stream with line/frame markers. It also owns the core's mode, advance enable and coordinate clear. It sits between the pixel source, the rotation core and the downstream consumer.

## Interface
- IMG_W, 1024, source image width in pixels
- IMG_H, 1024, source image height in pixels; also the rotated line length
- CNT_W, 20, pixel counter width; must satisfy 2^CNT_W ≥ IMG_W*IMG_H
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process one frame; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last output pixel is accepted
- in_valid / in_ready / in_data  in / out / in  1 / 1 / 8  source-order pixel stream (raster, row-major)
- out_valid / out_ready / out_data  out / in / out  1 / 1 / 8  rotated pixel stream
- out_sol  out  1  qualifies out_data as first pixel of a rotated line
- out_eof  out  1  qualifies out_data as last pixel of the frame
- core_mode  out  1  0 = write phase, 1 = rotated read phase
- core_ce  out  1  advance core coordinates one pixel, write in mode 0 / issue read in mode 1
- core_clr  out  1  synchronous clear of core coordinates to (0,0)
- core_wdata  out  8  pixel to core, equals in_data
- core_rdata  in  8  core read data, valid exactly 1 cycle after a core_ce in mode 1

## Operation
- States: IDLE, CLR_W, LOAD, CLR_R, ROTATE, DRAIN, DONE.
- IDLE: in_ready=0, core_ce=0, core_mode=0. start → CLR_W.
- CLR_W: core_clr=1, core_mode=0, one cycle → LOAD; pixel counter cleared.
- LOAD: in_ready=1; core_ce = in_valid (combinational); counter increments per transfer. Transfer with counter = IMG_W*IMG_H−1 → CLR_R.
- CLR_R: core_clr=1, core_mode=1, one cycle → ROTATE; issue and output counters cleared.
- ROTATE: core_mode=1. 2-entry output FIFO. core_ce=1 only when (FIFO occupancy + reads in flight) < 2. Each read's core_rdata is pushed into the FIFO the following cycle. Issue with issue count = IMG_W*IMG_H−1 → DRAIN.
- DRAIN: core_ce=0; stays until the last pixel is accepted (out_valid & out_ready & out_eof) → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- out_sol=1 when output index mod IMG_H == 0. out_eof=1 when output index == IMG_W*IMG_H−1. Output index counts accepted pixels.
- Counters are CNT_W bits and compare against constants; no wrap occurs within a frame.
- in_ready is 0 in every state except LOAD. No read is issued outside ROTATE.
- start during busy: ignored, no queuing. start and last-pixel acceptance in the same cycle: start ignored.
- Reset mid-frame: FSM → IDLE, FIFO emptied, in-flight read discarded; core contents are don't-care.

## Timing
- Reset values: busy=0, frame_done=0, in_ready=0, out_valid=0, out_sol=0, out_eof=0, out_data=0, core_mode=0, core_ce=0, core_clr=0.
- start at cycle 0 → busy=1 and CLR_W at cycle 1, in_ready=1 from cycle 2.
- Last input transfer at cycle t → CLR_R at t+1, first core_ce at t+2, first out_valid at t+4 (registered FIFO output).
- With out_ready held high, sustained throughput is 1 pixel/cycle.
- out_data, out_sol and out_eof hold stable while out_valid=1 and out_ready=0. out_valid drops only after acceptance.
- frame_done asserts the cycle after the out_eof transfer. busy falls in the same cycle.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15, both sides always ready → outputs 3,7,11,15,2,6,… ; out_sol on indices 0,4,8,12; out_eof on index 15; frame_done exactly once; 16 core_ce in each phase.
- Random in_valid gaps (50%) during LOAD → core_ce count equals transfers (16); output sequence unchanged.
- out_ready low for 10 cycles mid-ROTATE → no pixel lost or duplicated; core_ce stops with ≤2 pixels buffered; out_data stable while stalled.
- start pulsed during LOAD and during DRAIN → ignored; exactly one frame_done; a start after IDLE runs a second identical frame.
- rst asserted mid-ROTATE with out_valid=1 → all outputs reach reset values asynchronously; a fresh start yields a correct full frame.
- IMG_W=2, IMG_H=3 non-square → 6 outputs; out_sol every 3 pixels; the last issued core_ce triggers DRAIN.
